// File: rtl/delay_line_tank_ctrl.sv
// delay_line_tank_ctrl: sequences one circulating delay-line tank as word-addressed storage with single-request read/write service
module delay_line_tank_ctrl #(
    parameter  int WORDS      = 32,
    parameter  int WORD_WIDTH = 35,
    localparam int AW         = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int SW         = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  slot_stb,
    input  logic                  rx_bit,
    output logic                  tx_bit,
    output logic                  tx_stb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  clear_busy
);
    typedef enum logic [2:0] {CLEAR, IDLE, WAIT, XFER, DONE} state_t;
    state_t                state_q, state_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [AW-1:0]         word_q, word_d, addr_q, addr_d;
    logic                  write_q, write_d, err_q, err_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, resp_rdata_q, resp_rdata_d;
    logic                  tx_bit_q, tx_bit_d, tx_stb_q, tx_stb_d;
    logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic                  last_slot, last_word, start, xfer;
    assign last_slot  = slot_q == SW'(WORD_WIDTH);
    assign last_word  = word_q == AW'(WORDS - 1);
    assign start      = slot_stb && state_q == WAIT && slot_q == '0 && word_q == addr_q;
    assign xfer       = start || state_q == XFER;
    assign tx_bit     = tx_bit_q;
    assign tx_stb     = tx_stb_q;
    assign req_ready  = state_q == IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign clear_busy = state_q == CLEAR;
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        word_d       = word_q;
        addr_d       = addr_q;
        write_d      = write_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        tx_bit_d     = tx_bit_q;
        tx_stb_d     = slot_stb;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        if (slot_stb) begin
            slot_d   = last_slot ? '0 : slot_q + 1'b1;
            word_d   = !last_slot ? word_q : last_word ? '0 : word_q + 1'b1;
            tx_bit_d = (last_slot || state_q == CLEAR) ? 1'b0 : (xfer && write_q) ? wdata_q[WORD_WIDTH-1] : rx_bit;
            if (xfer && !last_slot) begin
                rdata_d = {rdata_q[WORD_WIDTH-2:0], rx_bit};
                wdata_d = wdata_q << 1;
            end
        end
        if (state_q == CLEAR && slot_stb && last_slot && last_word)
            state_d = IDLE;
        if (state_q == IDLE && req_valid) begin
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            err_d   = 32'(req_addr) >= WORDS;
            state_d = err_d ? DONE : WAIT;
        end
        if (start)
            state_d = XFER;
        if (state_q == XFER && slot_stb && last_slot)
            state_d = DONE;
        if (state_q == DONE) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
            resp_rdata_d = err_q ? '0 : rdata_q;
        end
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= CLEAR;
            slot_q       <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            tx_bit_q     <= 1'b0;
            tx_stb_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            tx_bit_q     <= tx_bit_d;
            tx_stb_q     <= tx_stb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end
endmodule
